// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and initiator FSM states.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R,
        RSP
    } state_t;

    function automatic logic is_wait(state_t s);
        return (s == WR_AW_W) || (s == WR_B) ||
               (s == RD_AR) || (s == RD_R);
    endfunction

endpackage

// File: rtl/axil_cfg_master_if.sv
// AXI-Lite bus bundle (no strobes: every write is a full word).
interface axil_cfg_master_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_timeout_ctr.sv
// Saturating wait-state counter; TIMEOUT_CYCLES of 0 never expires.
module axil_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && r_cnt != LIMIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT);
endmodule

// File: rtl/axil_cfg_master.sv
// Single-beat AXI-Lite initiator: one command in, one response out,
// with a wait-state timeout that aborts a hung slave.
module axil_cfg_master
    import axil_pkg::*;
#(
    parameter int C_AXIL_ADDR_WIDTH = 4,
    parameter int C_AXIL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES    = 256
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [C_AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [C_AXIL_DATA_WIDTH-1:0] cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [C_AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                   rsp_resp,
    output logic                         rsp_timeout,
    axil_cfg_master_if.master            m_axi
);
    state_t r_state;
    state_t w_state_next;

    logic [C_AXIL_ADDR_WIDTH-1:0] r_addr;
    logic [C_AXIL_DATA_WIDTH-1:0] r_wdata;
    logic [C_AXIL_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                   r_resp;
    logic                         r_timeout;
    logic                         r_aw_done;
    logic                         r_w_done;

    logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic w_expired, w_clear, w_enable;
    logic w_aw_hs, w_w_hs, w_b_hs, w_r_hs;

    axil_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expired(w_expired)
    );

    // Every state change restarts the wait budget of the next state.
    assign w_clear  = (w_state_next != r_state);
    assign w_enable = is_wait(r_state);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid)
                    w_state_next = cmd_write ? WR_AW_W : RD_AR;
            end
            WR_AW_W: begin
                if (w_expired) begin
                    w_state_next = RSP;
                end else begin
                    w_awvalid = !r_aw_done;
                    w_wvalid  = !r_w_done;
                    if ((r_aw_done || m_axi.awready) &&
                        (r_w_done  || m_axi.wready))
                        w_state_next = WR_B;
                end
            end
            WR_B: begin
                if (w_expired) begin
                    w_state_next = RSP;
                end else begin
                    w_bready = 1'b1;
                    if (m_axi.bvalid) w_state_next = RSP;
                end
            end
            RD_AR: begin
                if (w_expired) begin
                    w_state_next = RSP;
                end else begin
                    w_arvalid = 1'b1;
                    if (m_axi.arready) w_state_next = RD_R;
                end
            end
            RD_R: begin
                if (w_expired) begin
                    w_state_next = RSP;
                end else begin
                    w_rready = 1'b1;
                    if (m_axi.rvalid) w_state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_aw_hs = w_awvalid && m_axi.awready;
    assign w_w_hs  = w_wvalid  && m_axi.wready;
    assign w_b_hs  = w_bready  && m_axi.bvalid;
    assign w_r_hs  = w_rready  && m_axi.rvalid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
            r_timeout <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_enable && w_expired) begin
                r_resp    <= RESP_SLVERR;
                r_timeout <= 1'b1;
                r_rdata   <= '0;
            end else if (w_b_hs) begin
                r_resp    <= m_axi.bresp;
                r_timeout <= 1'b0;
                r_rdata   <= '0;
            end else if (w_r_hs) begin
                r_resp    <= m_axi.rresp;
                r_timeout <= 1'b0;
                r_rdata   <= m_axi.rdata;
            end
        end
    end

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awvalid = w_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wvalid  = w_wvalid;
    assign m_axi.bready  = w_bready;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arvalid = w_arvalid;
    assign m_axi.rready  = w_rready;

    assign cmd_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RSP);
    assign rsp_rdata   = r_rdata;
    assign rsp_resp    = r_resp;
    assign rsp_timeout = r_timeout;
endmodule

// File: tb/tb_axil_cfg_master.sv
// Bench for axil_cfg_master: delay-programmable slave plus a
// transaction-level model of response value and latency.
module tb_axil_cfg_master;
    import axil_pkg::*;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    always #5 clk = ~clk;

    axil_cfg_master_if #(.AW(4), .DW(32)) bus ();

    axil_cfg_master #(
        .C_AXIL_ADDR_WIDTH(4),
        .C_AXIL_DATA_WIDTH(32),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .aclk       (clk),
        .aresetn    (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .m_axi      (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Slave: each ready/valid rises once its channel has waited cfg_* cycles.
    int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
            bus.arready = 0; bus.rvalid = 0;
            bus.bresp = 0; bus.rresp = 0; bus.rdata = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (bus.awvalid) begin bus.awready = (aw_cnt >= cfg_aw); aw_cnt++; end
            else begin bus.awready = 0; aw_cnt = 0; end
            if (bus.wvalid) begin bus.wready = (w_cnt >= cfg_w); w_cnt++; end
            else begin bus.wready = 0; w_cnt = 0; end
            if (bus.bready) begin bus.bvalid = (b_cnt >= cfg_b); b_cnt++; end
            else begin bus.bvalid = 0; b_cnt = 0; end
            if (bus.arvalid) begin bus.arready = (ar_cnt >= cfg_ar); ar_cnt++; end
            else begin bus.arready = 0; ar_cnt = 0; end
            if (bus.rready) begin bus.rvalid = (r_cnt >= cfg_r); r_cnt++; end
            else begin bus.rvalid = 0; r_cnt = 0; end
            bus.bresp = cfg_bresp;
            bus.rresp = cfg_rresp;
            bus.rdata = cfg_rdata;
        end
    end

    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int c_awv = 0, c_wv = 0, c_bry = 0, c_rry = 0;
    logic [3:0]  last_awaddr = '0, last_araddr = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.awvalid && bus.awready) begin n_aw++; last_awaddr = bus.awaddr; end
            if (bus.wvalid && bus.wready) begin n_w++; last_wdata = bus.wdata; end
            if (bus.bvalid && bus.bready) n_b++;
            if (bus.arvalid && bus.arready) begin n_ar++; last_araddr = bus.araddr; end
            if (bus.rvalid && bus.rready) n_r++;
            if (bus.awvalid) c_awv++;
            if (bus.wvalid) c_wv++;
            if (bus.bready) c_bry++;
            if (bus.rready) c_rry++;
        end
    end

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;

    // Latency counted from the accept edge to the first cycle rsp_valid is seen.
    // A phase with a d-cycle slave delay lasts d+1 cycles, or TMO+1 if d >= TMO.
    function automatic exp_t model(bit wr, int d1a, int d1b, int d2,
                                   logic [1:0] r, logic [31:0] data);
        exp_t e;
        int p1;
        p1 = (wr && d1b > d1a) ? d1b : d1a;
        e.rdata = '0;
        e.tmo = 1'b0;
        if (p1 >= TMO) begin
            e.lat = TMO + 2; e.tmo = 1'b1; e.resp = 2'b10;
        end else if (d2 >= TMO) begin
            e.lat = p1 + TMO + 3; e.tmo = 1'b1; e.resp = 2'b10;
        end else begin
            e.lat = p1 + d2 + 3; e.resp = r;
            e.rdata = wr ? 32'h0 : data;
        end
        return e;
    endfunction

    function automatic logic [1:0] pick_resp();
        case ($urandom_range(0, 2))
            0: return RESP_OKAY;
            1: return RESP_SLVERR;
            default: return RESP_DECERR;
        endcase
    endfunction

    function automatic int pick_delay();
        if ($urandom_range(0, 9) == 0) return $urandom_range(TMO, TMO + 4);
        return $urandom_range(0, 5);
    endfunction

    task automatic do_cmd(input logic wr, input logic [3:0] a,
                          input logic [31:0] d, input int hold,
                          output int lat, output logic [31:0] rd,
                          output logic [1:0] rs, output logic to,
                          output bit stable, output bit ok);
        int n;
        ok = 1; stable = 1; lat = 0; rd = '0; rs = '0; to = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) ok = 0;
        @(posedge clk);
        #1 cmd_valid = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 200);
        if (!rsp_valid) begin ok = 0; return; end
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_rdata !== rd ||
                rsp_resp !== rs || rsp_timeout !== to) stable = 0;
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_axi: got %b want 00000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        end
        vectors++;
        if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got v=%b t=%b r=%b d=%h want zeros",
                rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        end
        rst_n = 1;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        int aw0, w0, b0;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_bresp = RESP_OKAY;
        aw0 = n_aw; w0 = n_w; b0 = n_b;
        do_cmd(1, 4'h0, 32'h0000ACE1, 0, lat, rd, rs, to, st, ok);
        vectors++;
        if (!ok || lat !== 3) begin
            miscompares++; $display("FAIL wr_latency: got %0d ok=%0d want 3", lat, ok);
        end
        vectors++;
        if (rs !== RESP_OKAY || to !== 1'b0 || rd !== 32'h0) begin
            miscompares++; $display("FAIL wr_rsp: got r=%b t=%b d=%h want 00 0 0", rs, to, rd);
        end
        vectors++;
        if (n_aw - aw0 !== 1 || n_w - w0 !== 1 || n_b - b0 !== 1) begin
            miscompares++;
            $display("FAIL wr_beats: got aw=%0d w=%0d b=%0d want 1 1 1",
                n_aw - aw0, n_w - w0, n_b - b0);
        end
        vectors++;
        if (last_awaddr !== 4'h0 || last_wdata !== 32'h0000ACE1) begin
            miscompares++;
            $display("FAIL wr_payload: got a=%h d=%h want 0 0000ace1", last_awaddr, last_wdata);
        end
    endtask

    task automatic test_aw_delay();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        int awv0, wv0, aw0;
        exp_t e;
        cfg_aw = 3; cfg_w = 0; cfg_b = 0; cfg_bresp = RESP_OKAY;
        e = model(1, 3, 0, 0, RESP_OKAY, 32'h0);
        awv0 = c_awv; wv0 = c_wv; aw0 = n_aw;
        do_cmd(1, 4'h4, 32'h5, 0, lat, rd, rs, to, st, ok);
        vectors++;
        if (c_awv - awv0 !== 4 || c_wv - wv0 !== 1) begin
            miscompares++;
            $display("FAIL aw_delay_valids: got awv=%0d wv=%0d want 4 1",
                c_awv - awv0, c_wv - wv0);
        end
        vectors++;
        if (!ok || lat !== e.lat || rs !== e.resp || n_aw - aw0 !== 1) begin
            miscompares++;
            $display("FAIL aw_delay_rsp: got lat=%0d r=%b aw=%0d want %0d %b 1",
                lat, rs, n_aw - aw0, e.lat, e.resp);
        end
        cfg_aw = 0;
    endtask

    task automatic test_read_delay();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        int rr0;
        exp_t e;
        cfg_ar = 0; cfg_r = 5; cfg_rdata = 32'hDEADBEEF; cfg_rresp = RESP_OKAY;
        e = model(0, 0, 0, 5, RESP_OKAY, 32'hDEADBEEF);
        rr0 = c_rry;
        do_cmd(0, 4'h8, 32'h0, 0, lat, rd, rs, to, st, ok);
        vectors++;
        if (!ok || rd !== 32'hDEADBEEF || rs !== RESP_OKAY || lat !== e.lat) begin
            miscompares++;
            $display("FAIL rd_rsp: got d=%h r=%b lat=%0d want deadbeef 00 %0d", rd, rs, lat, e.lat);
        end
        vectors++;
        if (c_rry - rr0 !== 6 || last_araddr !== 4'h8) begin
            miscompares++;
            $display("FAIL rd_rready: got rready=%0d addr=%h want 6 8", c_rry - rr0, last_araddr);
        end
        cfg_r = 0;
    endtask

    task automatic test_backpressure();
        int n, aw0;
        logic [31:0] rd; logic [1:0] rs; bit st, busy;
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_bresp = RESP_OKAY;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'h11;
        @(posedge clk);
        #1 cmd_addr = 4'hC; cmd_wdata = 32'h22;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        rd = rsp_rdata; rs = rsp_resp; aw0 = n_aw; st = 1; busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs) st = 0;
            if (cmd_ready) busy = 1;
        end
        vectors++;
        if (st !== 1'b1 || busy !== 1'b0 || n_aw !== aw0) begin
            miscompares++;
            $display("FAIL bp_hold: got stable=%0d cmd_ready_seen=%0d new_aw=%0d want 1 0 0",
                st, busy, n_aw - aw0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(posedge clk);
        #1 cmd_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
        vectors++;
        if (!rsp_valid || last_awaddr !== 4'hC || last_wdata !== 32'h22) begin
            miscompares++;
            $display("FAIL bp_second: got v=%b a=%h d=%h want 1 c 22", rsp_valid, last_awaddr, last_wdata);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    task automatic test_timeout();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        int br0;
        cfg_aw = 0; cfg_w = 0; cfg_b = 1000; cfg_bresp = RESP_OKAY;
        br0 = c_bry;
        do_cmd(1, 4'h0, 32'h1234, 2, lat, rd, rs, to, st, ok);
        vectors++;
        if (!ok || lat !== 19 || rs !== 2'b10 || to !== 1'b1 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL tmo_rsp: got lat=%0d r=%b t=%b d=%h want 19 10 1 0", lat, rs, to, rd);
        end
        vectors++;
        if (c_bry - br0 !== TMO) begin
            miscompares++; $display("FAIL tmo_bready: got %0d cycles want %0d", c_bry - br0, TMO);
        end
        cfg_b = 0;
    endtask

    task automatic test_reset_mid();
        int n, seen;
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        cfg_ar = 0; cfg_r = 1000;
        @(negedge clk);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'h8;
        @(posedge clk);
        #1 cmd_valid = 0;
        n = 0;
        while (!bus.rready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 0;
        #1;
        vectors++;
        if ({bus.arvalid, bus.rready, rsp_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_out: got ar=%b rr=%b rv=%b want 000",
                bus.arvalid, bus.rready, rsp_valid);
        end
        @(negedge clk);
        rst_n = 1;
        cfg_r = 0;
        seen = 0;
        @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++; $display("FAIL midrst_ready: got %b want 1", cmd_ready);
        end
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (rsp_valid) seen++; end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL midrst_norsp: got %0d rsp cycles want 0", seen);
        end
        do_cmd(1, 4'h4, 32'hA5A5A5A5, 0, lat, rd, rs, to, st, ok);
        vectors++;
        if (!ok || lat !== 3 || last_wdata !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL midrst_recover: got lat=%0d d=%h want 3 a5a5a5a5", lat, last_wdata);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic [1:0] rs; logic to; bit st, ok;
        bit wr; logic [3:0] a; logic [31:0] d; int hold; int aw0, ar0;
        exp_t e;
        for (int it = 0; it < 40; it++) begin
            wr = 1'($urandom_range(0, 1));
            a = 4'($urandom_range(0, 15));
            d = $urandom;
            hold = $urandom_range(0, 3);
            cfg_aw = pick_delay(); cfg_w = pick_delay(); cfg_b = pick_delay();
            cfg_ar = pick_delay(); cfg_r = pick_delay();
            cfg_bresp = pick_resp(); cfg_rresp = pick_resp(); cfg_rdata = $urandom;
            if (wr) e = model(1, cfg_aw, cfg_w, cfg_b, cfg_bresp, 32'h0);
            else    e = model(0, cfg_ar, 0, cfg_r, cfg_rresp, cfg_rdata);
            aw0 = n_aw; ar0 = n_ar;
            do_cmd(wr, a, d, hold, lat, rd, rs, to, st, ok);
            vectors++;
            if (!ok || lat !== e.lat || rs !== e.resp || to !== e.tmo || rd !== e.rdata) begin
                miscompares++;
                $display("FAIL rnd%0d_rsp: got lat=%0d r=%b t=%b d=%h want %0d %b %b %h",
                    it, lat, rs, to, rd, e.lat, e.resp, e.tmo, e.rdata);
            end
            vectors++;
            if (st !== 1'b1) begin
                miscompares++; $display("FAIL rnd%0d_stable: got %0d want 1", it, st);
            end
            if (!e.tmo) begin
                vectors++;
                if (wr && (n_aw - aw0 !== 1 || last_awaddr !== a || last_wdata !== d)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_wr: got aw=%0d a=%h d=%h want 1 %h %h",
                        it, n_aw - aw0, last_awaddr, last_wdata, a, d);
                end else if (!wr && (n_ar - ar0 !== 1 || last_araddr !== a)) begin
                    miscompares++;
                    $display("FAIL rnd%0d_rd: got ar=%0d a=%h want 1 %h",
                        it, n_ar - ar0, last_araddr, a);
                end
            end
        end
        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_basic();
        test_aw_delay();
        test_read_delay();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
